// File: rtl/branch_resolver_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolver_pkg
// Shared definitions for the branch resolver and the flag indicator:
//   - condition-code constants COND_NOP..COND_RET
//   - flag bit indices FLAG_Z/FLAG_C/FLAG_N (same order as the flag indicator)
//   - resolver FSM state encoding
// -----------------------------------------------------------------------------
package branch_resolver_pkg;

  localparam logic [3:0] COND_NOP  = 4'd0;
  localparam logic [3:0] COND_JMP  = 4'd1;
  localparam logic [3:0] COND_JZ   = 4'd2;
  localparam logic [3:0] COND_JNZ  = 4'd3;
  localparam logic [3:0] COND_JC   = 4'd4;
  localparam logic [3:0] COND_JNC  = 4'd5;
  localparam logic [3:0] COND_JN   = 4'd6;
  localparam logic [3:0] COND_JNN  = 4'd7;
  localparam logic [3:0] COND_CALL = 4'd8;
  localparam logic [3:0] COND_RET  = 4'd9;

  localparam int unsigned FLAG_Z = 32'd0;
  localparam int unsigned FLAG_C = 32'd1;
  localparam int unsigned FLAG_N = 32'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

endpackage

// File: rtl/branch_resolver_ret_stack.sv
// -----------------------------------------------------------------------------
// ret_stack
// DEPTH-entry LIFO of N-bit return addresses. Push and pop take effect on the
// clock edge; a push while full or a pop while empty is ignored. top_o shows
// the most recently pushed entry (undefined content while empty).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (empties the stack)
//   push_i          push push_data_i at the next edge (ignored when full)
//   pop_i           drop the top entry at the next edge (ignored when empty)
//   push_data_i     address to push
//   full_o/empty_o  occupancy flags
//   top_o           current top entry
// -----------------------------------------------------------------------------
module ret_stack #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [N-1:0] push_data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [N-1:0] top_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] top_ptr_s;
  logic [N-1:0]  mem_q [DEPTH];

  // Pointer counts entries, so the extra MSB distinguishes full from empty.
  assign full_o    = (ptr_q == PW'(DEPTH));
  assign empty_o   = (ptr_q == {PW{1'b0}});
  assign top_ptr_s = ptr_q - {{(PW-1){1'b0}}, 1'b1};
  assign top_o     = mem_q[top_ptr_s[AW-1:0]];

  // Next stack pointer; push has priority, the resolver never asserts both.
  always_comb begin
    ptr_d = ptr_q;
    if (push_i && !full_o) begin
      ptr_d = ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else if (pop_i && !empty_o) begin
      ptr_d = top_ptr_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Stack pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= {PW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Entry storage; contents above the pointer are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (rst_n && push_i && !full_o) begin
      mem_q[ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
// Holds the architectural Z/C/N flag register and resolves conditional jumps
// from decode against it. One request at a time (valid/ready); a resolution
// produces a one-cycle pc_load/br_taken pulse, and a taken branch is followed
// by a one-cycle flush.
// Optional build macro RET_STACK_EN adds a DEPTH-entry return stack for
// CALL/RET; without it CALL/RET behave as illegal codes and stack_err is 0.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flags_in, flags_we    flag write from the flag indicator (bit0 Z, 1 C, 2 N)
//   br_valid, br_ready    request handshake
//   br_cond, br_target    condition code and jump target
//   pc_ret                return address pushed by CALL
//   pc_load, pc_target    PC load pulse and address
//   br_taken              resolution pulse, 1 when taken
//   flush                 cycle after a taken resolution
//   flags_q               current flag register
//   stack_err             return-stack overflow/underflow pulse
// -----------------------------------------------------------------------------
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   flags_in,
  input  logic         flags_we,
  input  logic         br_valid,
  output logic         br_ready,
  input  logic [3:0]   br_cond,
  input  logic [N-1:0] br_target,
  input  logic [N-1:0] pc_ret,
  output logic         pc_load,
  output logic [N-1:0] pc_target,
  output logic         br_taken,
  output logic         flush,
  output logic [2:0]   flags_q,
  output logic         stack_err
);

  state_e       state_q, state_d;
  logic [2:0]   flags_d;
  logic         ready_q, ready_d;
  logic         pc_load_q, pc_load_d;
  logic         br_taken_q, br_taken_d;
  logic [N-1:0] pc_target_q, pc_target_d;
  logic         flush_q, flush_d;
  logic         stack_err_q, stack_err_d;

  logic         accept_s;
  logic [2:0]   eff_flags_s;
  logic         taken_s;
  logic [N-1:0] target_s;
  logic         err_s;

`ifdef RET_STACK_EN
  logic         push_s;
  logic         pop_s;
  logic         full_s;
  logic         empty_s;
  logic [N-1:0] top_s;

  ret_stack #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .push_data_i (pc_ret),
    .full_o      (full_s),
    .empty_o     (empty_s),
    .top_o       (top_s)
  );
`else
  // Return stack absent: pc_ret and DEPTH are intentionally unused.
  logic unused_s;
  assign unused_s = ^{pc_ret, (DEPTH > 32'sd1)};
`endif

  assign br_ready  = ready_q;
  assign pc_load   = pc_load_q;
  assign pc_target = pc_target_q;
  assign br_taken  = br_taken_q;
  assign flush     = flush_q;
  assign stack_err = stack_err_q;

  // Branch decision; a flag write in the acceptance cycle is bypassed in.
  always_comb begin
    accept_s    = br_valid && ready_q;
    eff_flags_s = flags_we ? flags_in : flags_q;
    taken_s     = 1'b0;
    target_s    = br_target;
    err_s       = 1'b0;
`ifdef RET_STACK_EN
    push_s      = 1'b0;
    pop_s       = 1'b0;
`endif
    case (br_cond)
      COND_NOP: taken_s = 1'b0;
      COND_JMP: taken_s = 1'b1;
      COND_JZ:  taken_s = eff_flags_s[FLAG_Z];
      COND_JNZ: taken_s = !eff_flags_s[FLAG_Z];
      COND_JC:  taken_s = eff_flags_s[FLAG_C];
      COND_JNC: taken_s = !eff_flags_s[FLAG_C];
      COND_JN:  taken_s = eff_flags_s[FLAG_N];
      COND_JNN: taken_s = !eff_flags_s[FLAG_N];
`ifdef RET_STACK_EN
      COND_CALL: begin
        if (!full_s) begin
          taken_s = 1'b1;
          push_s  = accept_s;
        end else begin
          err_s   = 1'b1;
        end
      end
      COND_RET: begin
        if (!empty_s) begin
          taken_s  = 1'b1;
          pop_s    = accept_s;
          target_s = top_s;
        end else begin
          err_s    = 1'b1;
        end
      end
`endif
      default: taken_s = 1'b0;
    endcase
  end

  // FSM next state and next registered outputs (outputs pulse for the state
  // entered on the following edge).
  always_comb begin
    state_d     = state_q;
    pc_load_d   = 1'b0;
    br_taken_d  = 1'b0;
    pc_target_d = {N{1'b0}};
    flush_d     = 1'b0;
    stack_err_d = 1'b0;
    flags_d     = flags_we ? flags_in : flags_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d     = ST_RESOLVE;
          pc_load_d   = taken_s;
          br_taken_d  = taken_s;
          pc_target_d = taken_s ? target_s : {N{1'b0}};
          stack_err_d = err_s;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_RESOLVE: begin
        // br_taken_q holds the registered decision during RESOLVE.
        if (br_taken_q) begin
          state_d = ST_FLUSH;
          flush_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State, flag register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      flags_q     <= 3'b000;
      ready_q     <= 1'b1;
      pc_load_q   <= 1'b0;
      br_taken_q  <= 1'b0;
      pc_target_q <= {N{1'b0}};
      flush_q     <= 1'b0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      ready_q     <= ready_d;
      pc_load_q   <= pc_load_d;
      br_taken_q  <= br_taken_d;
      pc_target_q <= pc_target_d;
      flush_q     <= flush_d;
      stack_err_q <= stack_err_d;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_branch_resolver
// Self-checking bench for branch_resolver (N = 8, DEPTH = 4). Directed
// scenarios followed by randomized requests checked against a reference
// model (flag register, condition rules, return-address queue).
// -----------------------------------------------------------------------------
module tb_branch_resolver;

  logic       clk;
  logic       rst_n;
  logic [2:0] flags_in;
  logic       flags_we;
  logic       br_valid;
  logic       br_ready;
  logic [3:0] br_cond;
  logic [7:0] br_target;
  logic [7:0] pc_ret;
  logic       pc_load;
  logic [7:0] pc_target;
  logic       br_taken;
  logic       flush;
  logic [2:0] flags_q;
  logic       stack_err;

  int total = 0;
  int bad   = 0;

  branch_resolver #(.N(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flags_in  (flags_in),
    .flags_we  (flags_we),
    .br_valid  (br_valid),
    .br_ready  (br_ready),
    .br_cond   (br_cond),
    .br_target (br_target),
    .pc_ret    (pc_ret),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .br_taken  (br_taken),
    .flush     (flush),
    .flags_q   (flags_q),
    .stack_err (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time limit)");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for br_ready, presents a request for one edge.
  // Entered and left at 1 time unit after a rising edge.
  task automatic issue(input logic [3:0] c, input logic [7:0] t, input logic [7:0] r,
                       input logic we, input logic [2:0] fi);
    int n = 0;
    while (br_ready !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (br_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_timeout: br_ready=%b required 1", br_ready);
    end
    br_valid = 1'b1; br_cond = c; br_target = t; pc_ret = r;
    flags_we = we; flags_in = fi;
    @(posedge clk); #1;
    br_valid = 1'b0; flags_we = 1'b0;
  endtask

  task automatic write_flags(input logic [2:0] f);
    flags_we = 1'b1; flags_in = f;
    @(posedge clk); #1;
    flags_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flags_in = 3'b000; flags_we = 1'b0; br_valid = 1'b0;
    br_cond = 4'd0; br_target = 8'h00; pc_ret = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if ({br_ready, pc_load, br_taken, flush, stack_err, flags_q, pc_target} !== {5'b10000, 3'b000, 8'h00}) begin
      bad++;
      $display("FAIL reset: ready/load/taken/flush/err=%b%b%b%b%b flags=%b tgt=%h required 10000 000 00",
               br_ready, pc_load, br_taken, flush, stack_err, flags_q, pc_target);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_taken_jz();
    write_flags(3'b001);
    issue(4'b0010, 8'h3C, 8'h00, 1'b0, 3'b000);
    total++;
    if ({pc_load, br_taken, flush, pc_target} !== {3'b110, 8'h3C}) begin
      bad++;
      $display("FAIL jz_taken: load/taken/flush=%b%b%b tgt=%h required 110 3c", pc_load, br_taken, flush, pc_target);
    end
    @(posedge clk); #1;
    total++;
    if ({flush, br_ready, pc_load, br_taken} !== 4'b1000) begin
      bad++;
      $display("FAIL jz_flush: flush/ready/load/taken=%b%b%b%b required 1000", flush, br_ready, pc_load, br_taken);
    end
    @(posedge clk); #1;
    total++;
    if ({flush, br_ready} !== 2'b01) begin
      bad++;
      $display("FAIL jz_after_flush: flush/ready=%b%b required 01", flush, br_ready);
    end
  endtask

  task automatic test_not_taken();
    write_flags(3'b000);
    issue(4'b0010, 8'h10, 8'h00, 1'b0, 3'b000);
    total++;
    if ({pc_load, br_taken, flush} !== 3'b000) begin
      bad++;
      $display("FAIL jz_not_taken: load/taken/flush=%b%b%b required 000", pc_load, br_taken, flush);
    end
    @(posedge clk); #1;
    total++;
    if ({br_ready, flush, pc_load} !== 3'b100) begin
      bad++;
      $display("FAIL jz_not_taken_next: ready/flush/load=%b%b%b required 100", br_ready, flush, pc_load);
    end
  endtask

  task automatic test_bypass();
    total++;
    if (flags_q !== 3'b000) begin
      bad++;
      $display("FAIL bypass_pre: flags_q=%b required 000", flags_q);
    end
    issue(4'b0100, 8'h55, 8'h00, 1'b1, 3'b010);
    total++;
    if ({pc_load, br_taken, pc_target} !== {2'b11, 8'h55}) begin
      bad++;
      $display("FAIL bypass_jc: load/taken=%b%b tgt=%h required 11 55", pc_load, br_taken, pc_target);
    end
    total++;
    if (flags_q !== 3'b010) begin
      bad++;
      $display("FAIL bypass_flags: flags_q=%b required 010", flags_q);
    end
  endtask

  task automatic test_illegal();
    issue(4'b1100, 8'hFF, 8'h00, 1'b0, 3'b000);
    total++;
    if ({pc_load, br_taken, stack_err, flags_q} !== {3'b000, 3'b010}) begin
      bad++;
      $display("FAIL illegal: load/taken/err=%b%b%b flags=%b required 000 010", pc_load, br_taken, stack_err, flags_q);
    end
    @(posedge clk); #1;
    total++;
    if ({flush, br_ready} !== 2'b01) begin
      bad++;
      $display("FAIL illegal_next: flush/ready=%b%b required 01", flush, br_ready);
    end
  endtask

  task automatic test_stack();
`ifdef RET_STACK_EN
    for (int i = 1; i <= 4; i++) begin
      issue(4'b1000, 8'hA0 + 8'(i), 8'(i), 1'b0, 3'b000);
      total++;
      if ({pc_load, br_taken, stack_err, pc_target} !== {3'b110, 8'hA0 + 8'(i)}) begin
        bad++;
        $display("FAIL call_%0d: load/taken/err=%b%b%b tgt=%h required 110 %h", i, pc_load, br_taken, stack_err, pc_target, 8'hA0 + 8'(i));
      end
    end
    issue(4'b1000, 8'hB0, 8'h05, 1'b0, 3'b000);
    total++;
    if ({pc_load, br_taken, stack_err} !== 3'b001) begin
      bad++;
      $display("FAIL call_overflow: load/taken/err=%b%b%b required 001", pc_load, br_taken, stack_err);
    end
    for (int i = 4; i >= 1; i--) begin
      issue(4'b1001, 8'hEE, 8'h00, 1'b0, 3'b000);
      total++;
      if ({pc_load, br_taken, stack_err, pc_target} !== {3'b110, 8'(i)}) begin
        bad++;
        $display("FAIL ret_%0d: load/taken/err=%b%b%b tgt=%h required 110 %h", i, pc_load, br_taken, stack_err, pc_target, 8'(i));
      end
    end
    issue(4'b1001, 8'hEE, 8'h00, 1'b0, 3'b000);
    total++;
    if ({pc_load, br_taken, stack_err} !== 3'b001) begin
      bad++;
      $display("FAIL ret_underflow: load/taken/err=%b%b%b required 001", pc_load, br_taken, stack_err);
    end
    @(posedge clk); #1;
    total++;
    if ({stack_err, br_ready} !== 2'b01) begin
      bad++;
      $display("FAIL err_pulse: err/ready=%b%b required 01", stack_err, br_ready);
    end
`else
    issue(4'b1000, 8'hB0, 8'h05, 1'b0, 3'b000);
    total++;
    if ({pc_load, br_taken, stack_err} !== 3'b000) begin
      bad++;
      $display("FAIL call_disabled: load/taken/err=%b%b%b required 000", pc_load, br_taken, stack_err);
    end
    issue(4'b1001, 8'hB1, 8'h00, 1'b0, 3'b000);
    total++;
    if ({pc_load, br_taken, stack_err} !== 3'b000) begin
      bad++;
      $display("FAIL ret_disabled: load/taken/err=%b%b%b required 000", pc_load, br_taken, stack_err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    write_flags(3'b101);
    issue(4'b0001, 8'h77, 8'h00, 1'b0, 3'b000);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if ({pc_load, br_taken, flush, flags_q, br_ready} !== {3'b000, 3'b000, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid: load/taken/flush=%b%b%b flags=%b ready=%b required 000 000 1",
               pc_load, br_taken, flush, flags_q, br_ready);
    end
    @(posedge clk); #1;
    total++;
    if ({pc_load, flush, br_ready} !== 3'b001) begin
      bad++;
      $display("FAIL reset_mid_after: load/flush/ready=%b%b%b required 001", pc_load, flush, br_ready);
    end
  endtask

  // Randomized requests against the model; starts from the reset state.
  task automatic test_random();
    logic [2:0] m_flags;
    logic [7:0] m_stack[$];
    logic [3:0] c;
    logic [7:0] t, r, exp_tgt;
    logic [2:0] fi, fi2, eff;
    logic       we, we2, exp_tk, exp_err;
    int         fidx;
    m_flags = 3'b000;
    for (int it = 0; it < 300; it++) begin
      c  = 4'($urandom_range(0, 15));
      t  = 8'($urandom);
      r  = 8'($urandom);
      we = 1'($urandom_range(0, 1));
      fi = 3'($urandom_range(0, 7));
      eff = we ? fi : m_flags;
      exp_tk = 1'b0; exp_tgt = t; exp_err = 1'b0;
      if (c == 4'd1) begin
        exp_tk = 1'b1;
      end else if (c >= 4'd2 && c <= 4'd7) begin
        // pairs (JZ,JNZ),(JC,JNC),(JN,JNN): flag index then odd code inverts
        fidx   = (int'(c) - 2) / 2;
        exp_tk = eff[fidx] ^ c[0];
      end
`ifdef RET_STACK_EN
      else if (c == 4'd8) begin
        if (m_stack.size() < 4) begin
          m_stack.push_back(r);
          exp_tk = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
      end else if (c == 4'd9) begin
        if (m_stack.size() > 0) begin
          exp_tgt = m_stack.pop_back();
          exp_tk  = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
      end
`endif
      m_flags = eff;
      issue(c, t, r, we, fi);
      total++;
      if ({pc_load, br_taken, stack_err} !== {exp_tk, exp_tk, exp_err} ||
          (exp_tk && pc_target !== exp_tgt)) begin
        bad++;
        $display("FAIL rand_resolve it=%0d cond=%h: load/taken/err=%b%b%b tgt=%h required %b%b%b %h",
                 it, c, pc_load, br_taken, stack_err, pc_target, exp_tk, exp_tk, exp_err, exp_tgt);
      end
      we2 = 1'($urandom_range(0, 1));
      fi2 = 3'($urandom_range(0, 7));
      flags_we = we2; flags_in = fi2;
      @(posedge clk); #1;
      flags_we = 1'b0;
      if (we2) m_flags = fi2;
      total++;
      if ({flush, br_ready, flags_q} !== {exp_tk, !exp_tk, m_flags}) begin
        bad++;
        $display("FAIL rand_after it=%0d: flush/ready=%b%b flags=%b required %b%b %b",
                 it, flush, br_ready, flags_q, exp_tk, !exp_tk, m_flags);
      end
    end
  endtask

  initial begin
    test_reset();
    test_taken_jz();
    test_not_taken();
    test_bypass();
    test_illegal();
    test_stack();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumer side of the ALU flag path: holds the architectural Z/C/N flag register written by the flag indicator and resolves conditional jumps against it.
- Sits between the decode stage and the program counter.
- Accepts one branch request at a time via valid/ready.
- Produces a one-cycle PC-load pulse with the target address, plus a one-cycle flush window after a taken branch.

Parameters:
- N, 8, program-address width (bits of br_target, pc_ret, pc_target).
- DEPTH, 4, return-stack entries (used only with RET_STACK_EN; power of two, 2..16).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- flags_in  in  3  flags from the flag indicator; bit0 = Z, bit1 = C, bit2 = N.
- flags_we  in  1  capture flags_in this cycle.
- br_valid  in  1  branch request valid.
- br_ready  out  1  resolver can accept a request.
- br_cond  in  4  condition code (see Behaviour).
- br_target  in  N  jump target address.
- pc_ret  in  N  address of the instruction after the branch (CALL return address).
- pc_load  out  1  one-cycle pulse; PC must load pc_target.
- pc_target  out  N  address to load; valid while pc_load = 1.
- br_taken  out  1  one-cycle pulse, coincident with resolution, = 1 when the branch was taken.
- flush  out  1  high for the cycle after a taken resolution; decode discards its instruction.
- flags_q  out  3  current flag register.
- stack_err  out  1  one-cycle pulse on stack overflow/underflow (0 when RET_STACK_EN is undefined).

Behaviour:
- Reset (rst_n = 0 at a rising edge): all outputs and state clear.
  - flags_q = 000, state = IDLE, br_ready = 1.
  - pc_load, br_taken, flush, stack_err = 0; pc_target = 0.
  - Stack pointer = 0 (empty).
  - Reset mid-operation aborts the pending request; no pc_load is issued.
- Flag register: on flags_we = 1, flags_q <= flags_in at the next edge. Otherwise flags_q holds.
- Handshake:
  - A request is accepted on an edge where br_valid = 1 and br_ready = 1.
  - br_cond, br_target, pc_ret are sampled on that edge.
  - br_ready = 1 only in IDLE.
- Flag bypass: evaluation uses effective flags = flags_in if flags_we = 1 in the acceptance cycle, else flags_q.
- Conditions: taken when
  - 0000 NOP: never.
  - 0001 JMP: always.
  - 0010 JZ: Z.
  - 0011 JNZ: !Z.
  - 0100 JC: C.
  - 0101 JNC: !C.
  - 0110 JN: N.
  - 0111 JNN: !N.
  - 1000 CALL: see Optional Feature.
  - 1001 RET: see Optional Feature.
  - 1010-1111: illegal, never taken, no other effect.
- FSM states: IDLE, RESOLVE, FLUSH.
  - IDLE -> RESOLVE on acceptance; the taken decision is registered.
  - RESOLVE lasts exactly 1 cycle:
    - br_taken = decision.
    - pc_load = decision; pc_target = br_target (or popped address for RET).
    - Next state FLUSH if taken, else IDLE.
  - FLUSH lasts exactly 1 cycle: flush = 1, br_ready = 0. Next state IDLE.
- Latency:
  - Acceptance edge -> pc_load visible the following cycle.
  - Back-to-back throughput: one request every 2 cycles if not taken, every 3 cycles if taken.
- flags_we is honoured in every state; flag updates are never blocked by the FSM.

Optional Feature:
- Macro: RET_STACK_EN.
- Defined:
  - DEPTH-entry LIFO of N-bit return addresses, pointer width $clog2(DEPTH)+1.
  - CALL: if not full, push pc_ret and take the branch to br_target. If full, no push, not taken, stack_err pulses in RESOLVE.
  - RET: if not empty, pop and take the branch to the popped address. If empty, not taken, stack_err pulses.
  - Push/pop commit on the acceptance edge.
- Undefined:
  - CALL and RET are treated as illegal codes (never taken).
  - No stack storage; stack_err is tied to 0.

Decomposition:
- Shared package holds:
  - Condition-code constants COND_NOP..COND_RET.
  - Flag bit indices FLAG_Z = 0, FLAG_C = 1, FLAG_N = 2; the flag indicator uses the same indices.
  - FSM state encoding.
- One sub-module, ret_stack: LIFO with push, pop, full, empty, top; instantiated only under RET_STACK_EN.

Test Plan:
- Reset, then flags_we = 1 with flags_in = 001; accept JZ with target 8'h3C -> next cycle pc_load = 1, pc_target = 3C, br_taken = 1; following cycle flush = 1, br_ready = 0; then br_ready = 1.
- flags_q = 000; accept JZ with target 8'h10 -> br_taken = 0, pc_load = 0, no flush, br_ready = 1 one cycle after RESOLVE.
- Bypass: flags_q = 000, and in the same cycle flags_we = 1 with flags_in = 010 and a JC request (target 8'h55) is accepted -> pc_load = 1, pc_target = 55.
- Illegal code 4'b1100 with target 8'hFF -> not taken; flags_q unchanged; no stack_err.
- With RET_STACK_EN and DEPTH = 4: 4 CALLs with pc_ret = 01..04 all taken; 5th CALL -> not taken, stack_err = 1. Then 4 RETs -> pc_target = 04, 03, 02, 01; 5th RET -> not taken, stack_err = 1.
- rst_n = 0 during RESOLVE of a taken JMP -> no pc_load, flags_q = 000, br_ready = 1 in the cycle after reset deasserts.
